// File: rtl/mc_controller.sv
// mc_controller: Moore main control FSM for the multicycle MIPS datapath.
// It steps each instruction through fetch, decode, address, memory, execute
// and writeback. It drives the datapath mux selects, the write enables and
// the 3-bit aluop that the ALU decoder consumes. FETCH, MEMRD and MEMWR
// stall until memready.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   op[5:0]   in   opcode held in the instruction register
//   jr        in   funct==8 indication from the ALU decoder (used in DECODE)
//   memready  in   memory access completes this cycle
//   irwrite, pcwrite, branch, memwrite, regwrite   out  write enables
//   iord, alusrca, alusrcb[1:0], pcsrc[1:0], regdst, memtoreg  out  mux selects
//   aluop[2:0] out  000 add, 001 sub, 010 funct, 011 or, 100 and
//   illegal    out  one-cycle pulse in DECODE on an unsupported opcode
//   state      out  current state code (debug)
module mc_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               jr,
    input  logic               memready,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               branch,
    output logic               memwrite,
    output logic               regwrite,
    output logic               iord,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic               regdst,
    output logic               memtoreg,
    output logic [2:0]         aluop,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = STATE_W'(0),
        S_DECODE = STATE_W'(1),
        S_MEMADR = STATE_W'(2),
        S_MEMRD  = STATE_W'(3),
        S_MEMWB  = STATE_W'(4),
        S_MEMWR  = STATE_W'(5),
        S_RTEXEC = STATE_W'(6),
        S_ALUWB  = STATE_W'(7),
        S_BRANCH = STATE_W'(8),
        S_IEXEC  = STATE_W'(9),
        S_IWB    = STATE_W'(10),
        S_JUMP   = STATE_W'(11)
    } state_t;

    state_t r_state;

    logic w_irwrite, w_pcwrite, w_branch, w_memwrite, w_regwrite, w_illegal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  if (memready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW:               r_state <= S_MEMADR;
                        OP_R:                       r_state <= jr ? S_JUMP : S_RTEXEC;
                        OP_BEQ:                     r_state <= S_BRANCH;
                        OP_ADDI, OP_ORI, OP_ANDI:   r_state <= S_IEXEC;
                        OP_J:                       r_state <= S_JUMP;
                        default:                    r_state <= S_FETCH;
                    endcase
                end
                // Only lw and sw reach MEMADR, so sw vs. not-sw is enough.
                S_MEMADR: r_state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (memready) r_state <= S_MEMWB;
                S_MEMWB:  r_state <= S_FETCH;
                S_MEMWR:  if (memready) r_state <= S_FETCH;
                S_RTEXEC: r_state <= S_ALUWB;
                S_ALUWB:  r_state <= S_FETCH;
                S_BRANCH: r_state <= S_FETCH;
                S_IEXEC:  r_state <= S_IWB;
                S_IWB:    r_state <= S_FETCH;
                S_JUMP:   r_state <= S_FETCH;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode from the registered state only. The exceptions are the
    // memready gating in FETCH and the op-dependent selects. op is stable in
    // those states because IR is only written in FETCH.
    always_comb begin
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_illegal  = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        aluop      = 3'b000;
        case (r_state)
            S_FETCH: begin
                alusrcb   = 2'b01;
                w_irwrite = memready;
                w_pcwrite = memready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_R, OP_LW, OP_SW, OP_BEQ,
                    OP_ADDI, OP_ORI, OP_ANDI, OP_J: w_illegal = 1'b0;
                    default:                        w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
            end
            S_RTEXEC: begin
                alusrca = 1'b1;
                aluop   = 3'b010;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                aluop    = 3'b001;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op)
                    OP_ORI:  aluop = 3'b011;
                    OP_ANDI: aluop = 3'b100;
                    default: aluop = 3'b000;
                endcase
            end
            S_IWB: w_regwrite = 1'b1;
            S_JUMP: begin
                w_pcwrite = 1'b1;
                pcsrc     = (op == OP_R) ? 2'b11 : 2'b10;
            end
            default: ;
        endcase
    end

    // Reset kills every write immediately, even combinational ones in FETCH.
    assign irwrite  = w_irwrite  & reset;
    assign pcwrite  = w_pcwrite  & reset;
    assign branch   = w_branch   & reset;
    assign memwrite = w_memwrite & reset;
    assign regwrite = w_regwrite & reset;
    assign illegal  = w_illegal  & reset;
    assign state    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       jr;
    logic       memready;
    logic       irwrite, pcwrite, branch, memwrite, regwrite, iord, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       regdst, memtoreg, illegal;
    logic [2:0] aluop;
    logic [3:0] state;

    always #5 clk = ~clk;

    mc_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .jr(jr), .memready(memready),
        .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch), .memwrite(memwrite),
        .regwrite(regwrite), .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .regdst(regdst), .memtoreg(memtoreg), .aluop(aluop),
        .illegal(illegal), .state(state)
    );

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, ANDI = 6'b001100, J = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    // {state, irwrite, pcwrite, branch, memwrite, regwrite, iord, alusrca,
    //  alusrcb, pcsrc, regdst, memtoreg, aluop, illegal}
    logic [20:0] got;
    assign got = {state, irwrite, pcwrite, branch, memwrite, regwrite, iord, alusrca,
                  alusrcb, pcsrc, regdst, memtoreg, aluop, illegal};

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [20:0] pk(input logic [3:0] st, input bit ir, input bit pcw,
                                       input bit br, input bit mw, input bit rw,
                                       input bit io, input bit asa, input bit [1:0] asb,
                                       input bit [1:0] pcs, input bit rd, input bit m2r,
                                       input bit [2:0] aop, input bit ill);
        return {st, ir, pcw, br, mw, rw, io, asa, asb, pcs, rd, m2r, aop, ill};
    endfunction

    // Reference: what the datapath must see in each step of an instruction.
    function automatic logic [20:0] model_out(input logic [3:0] s, input bit m, input logic [5:0] o);
        bit ir = 0, pcw = 0, br = 0, mw = 0, rw = 0, io = 0, asa = 0, rd = 0, m2r = 0, ill = 0;
        bit [1:0] asb = 0, pcs = 0;
        bit [2:0] aop = 0;
        case (s)
            4'd0:  begin ir = m; pcw = m; asb = 2'b01; end
            4'd1:  begin
                       asb = 2'b11;
                       ill = !(o inside {R, LW, SW, BEQ, ADDI, ORI, ANDI, J});
                   end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  io = 1;
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin io = 1; mw = 1; end
            4'd6:  begin asa = 1; aop = 3'b010; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin asa = 1; aop = 3'b001; pcs = 2'b01; br = 1; end
            4'd9:  begin
                       asa = 1; asb = 2'b10;
                       aop = (o == ORI) ? 3'b011 : (o == ANDI) ? 3'b100 : 3'b000;
                   end
            4'd10: rw = 1;
            4'd11: begin pcw = 1; pcs = (o == R) ? 2'b11 : 2'b10; end
            default: ;
        endcase
        return pk(s, ir, pcw, br, mw, rw, io, asa, asb, pcs, rd, m2r, aop, ill);
    endfunction

    task automatic check(input string nm, input logic [20:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %06h expected %06h", nm, got, exp);
        end
    endtask

    // Inputs are driven on the falling edge and held across the next rising edge.
    task automatic cyc(input logic [5:0] o, input bit j, input bit m,
                       input logic [20:0] e, input string nm);
        @(negedge clk);
        op = o; jr = j; memready = m;
        #1;
        check(nm, e);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic        jr;
        logic        mr;
        logic [20:0] exp;
        string       nm;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic [5:0] o, input bit j, input bit m,
                        input logic [20:0] e, input string nm);
        vec_t v;
        v.op = o; v.jr = j; v.mr = m; v.exp = e; v.nm = nm;
        tbl.push_back(v);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [20:0] fetch1, fetch0, dec;
        fetch1 = pk(0, 1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 3'b000, 0);
        fetch0 = pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 3'b000, 0);
        dec    = pk(1, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 3'b000, 0);

        // Reset held low with memready high: enables must stay 0.
        reset = 1'b0; op = R; jr = 1'b0; memready = 1'b1;
        #12;
        check("reset_state", fetch0);
        @(negedge clk);
        memready = 1'b0;
        reset = 1'b1;

        // lw
        addv(LW, 0, 1, fetch1, "lw_fetch");
        addv(LW, 0, 1, dec, "lw_decode");
        addv(LW, 0, 1, pk(2, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 3'b000, 0), "lw_memadr");
        addv(LW, 0, 1, pk(3, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0), "lw_memrd");
        addv(LW, 0, 1, pk(4, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 1, 3'b000, 0), "lw_memwb");
        // FETCH stall three cycles, then ori
        addv(ORI, 0, 0, fetch0, "stall1");
        addv(ORI, 0, 0, fetch0, "stall2");
        addv(ORI, 0, 0, fetch0, "stall3");
        addv(ORI, 0, 1, fetch1, "ori_fetch");
        addv(ORI, 0, 1, dec, "ori_decode");
        addv(ORI, 0, 1, pk(9, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 3'b011, 0), "ori_iexec");
        addv(ORI, 0, 1, pk(10, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0), "ori_iwb");
        // andi
        addv(ANDI, 0, 1, fetch1, "andi_fetch");
        addv(ANDI, 0, 1, dec, "andi_decode");
        addv(ANDI, 0, 1, pk(9, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 3'b100, 0), "andi_iexec");
        addv(ANDI, 0, 1, pk(10, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0), "andi_iwb");
        // jr
        addv(R, 1, 1, fetch1, "jr_fetch");
        addv(R, 1, 1, dec, "jr_decode");
        addv(R, 1, 1, pk(11, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 3'b000, 0), "jr_jump");
        // R-type
        addv(R, 0, 1, fetch1, "r_fetch");
        addv(R, 0, 1, dec, "r_decode");
        addv(R, 0, 1, pk(6, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 3'b010, 0), "r_rtexec");
        addv(R, 0, 1, pk(7, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1, 0, 3'b000, 0), "r_aluwb");
        // illegal opcode
        addv(BAD, 0, 1, fetch1, "ill_fetch");
        addv(BAD, 0, 1, pk(1, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 3'b000, 1), "ill_decode");
        // beq
        addv(BEQ, 0, 1, fetch1, "beq_fetch");
        addv(BEQ, 0, 1, dec, "beq_decode");
        addv(BEQ, 0, 1, pk(8, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b01, 0, 0, 3'b001, 0), "beq_branch");
        // sw with one MEMWR wait
        addv(SW, 0, 1, fetch1, "sw_fetch");
        addv(SW, 0, 1, dec, "sw_decode");
        addv(SW, 0, 1, pk(2, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 3'b000, 0), "sw_memadr");
        addv(SW, 0, 0, pk(5, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0), "sw_memwr_wait");
        addv(SW, 0, 1, pk(5, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0), "sw_memwr");
        // j
        addv(J, 0, 1, fetch1, "j_fetch");
        addv(J, 0, 1, dec, "j_decode");
        addv(J, 0, 1, pk(11, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 3'b000, 0), "j_jump");

        foreach (tbl[i]) cyc(tbl[i].op, tbl[i].jr, tbl[i].mr, tbl[i].exp, tbl[i].nm);

        // Reset asserted mid-MEMWR, between clock edges.
        cyc(SW, 0, 1, fetch1, "rsw_fetch");
        cyc(SW, 0, 1, dec, "rsw_decode");
        cyc(SW, 0, 1, pk(2, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 3'b000, 0), "rsw_memadr");
        cyc(SW, 0, 0, pk(5, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0), "rsw_memwr");
        reset = 1'b0;
        memready = 1'b1;
        #1;
        check("rst_async", fetch0);
        @(negedge clk);
        #1;
        check("rst_held", fetch0);
        memready = 1'b0;
        reset = 1'b1;
        cyc(J, 0, 0, fetch0, "post_rst_wait");
        cyc(J, 0, 1, fetch1, "post_rst_fetch");
        cyc(J, 0, 1, dec, "post_rst_decode");
        cyc(J, 0, 1, pk(11, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 3'b000, 0), "post_rst_jump");

        // Randomized instruction stream against the step-list reference.
        for (int i = 0; i < 250; i++) begin
            logic [5:0] o;
            bit         j;
            int         steps[$];
            case ($urandom_range(0, 9))
                0: o = R;    1: o = LW;   2: o = SW;  3: o = BEQ;
                4: o = ADDI; 5: o = ORI;  6: o = ANDI; 7: o = J;
                default: o = 6'($urandom_range(0, 63));
            endcase
            j = 1'($urandom_range(0, 1));
            steps = '{0, 1};
            case (o)
                LW:               steps = '{0, 1, 2, 3, 4};
                SW:               steps = '{0, 1, 2, 5};
                R:                steps = j ? '{0, 1, 11} : '{0, 1, 6, 7};
                BEQ:              steps = '{0, 1, 8};
                ADDI, ORI, ANDI:  steps = '{0, 1, 9, 10};
                J:                steps = '{0, 1, 11};
                default:          steps = '{0, 1};
            endcase
            foreach (steps[k]) begin
                logic [3:0] s;
                bit         m;
                s = 4'(steps[k]);
                if (s == 0 || s == 3 || s == 5) begin
                    int stall = 0;
                    do begin
                        m = (stall >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
                        cyc(o, j, m, model_out(s, m, o), $sformatf("rand_i%0d_s%0d", i, s));
                        stall++;
                    end while (!m);
                end else begin
                    m = 1'($urandom_range(0, 1));
                    cyc(o, j, m, model_out(s, m, o), $sformatf("rand_i%0d_s%0d", i, s));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
